// File: rtl/skolem_sweep_ctrl.sv
// skolem_sweep_ctrl
//   Walks every (s,t) pair of a W-bit Skolem-function block for the
//   condition "(x udiv s) signed<= t", captures the returned candidate x,
//   checks it, and keeps pass/fail/vacuous counts plus the first failure.
//
// Optional feature macro: SKOLEM_EXIST_SCAN_EN
//   When defined, a failing candidate triggers an exhaustive scan over x'
//   to tell real failures (some x' works) from vacuous vectors (none does).
//   When undefined, every violation counts as a failure and vac_cnt is 0.
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   start             one-cycle pulse that begins a sweep (ignored while busy)
//   busy, done        sweep in progress / one-cycle completion pulse
//   sk_s, sk_t        registered operands driven to the Skolem block
//   sk_x              candidate returned by the Skolem block
//   pass_cnt, fail_cnt, vac_cnt   vector statistics (2W+1 bits)
//   ff_valid, ff_s, ff_t, ff_x    first failing vector
//
// state  | meaning
// IDLE   | waiting for start; results of the last sweep held
// ISSUE  | sk_s/sk_t stable, Skolem block evaluating
// WAIT   | extra SK_LAT cycles for a pipelined Skolem block
// CHECK  | sample sk_x and test the constraint
// SCAN   | search x' = 0..2^W-1 for any satisfying value (feature only)
// ADV    | step to the next (s,t) pair, or finish after the last one
// DONE   | one-cycle done pulse
module skolem_sweep_ctrl #(
  parameter int W      = 4,
  parameter int SK_LAT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sk_s,
  output logic [W-1:0] sk_t,
  input  logic [W-1:0] sk_x,
  output logic [2*W:0] pass_cnt,
  output logic [2*W:0] fail_cnt,
  output logic [2*W:0] vac_cnt,
  output logic         ff_valid,
  output logic [W-1:0] ff_s,
  output logic [W-1:0] ff_t,
  output logic [W-1:0] ff_x
);

  localparam int CW = 2*W + 1;
  localparam int LW = (SK_LAT > 2) ? $clog2(SK_LAT) : 1;
  // Latency timer counts down from SK_LAT-1; WAIT lasts SK_LAT cycles.
  localparam logic [LW-1:0] LAT_M1 = (SK_LAT > 0) ? LW'(SK_LAT - 1) : '0;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ISSUE, ST_WAIT, ST_CHECK, ST_ADV, ST_DONE
`ifdef SKOLEM_EXIST_SCAN_EN
    , ST_SCAN
`endif
  } state_t;

  // s == 0 yields all-ones quotient (SMT-LIB udiv semantics).
  function automatic logic holds(input logic [W-1:0] x,
                                 input logic [W-1:0] s,
                                 input logic [W-1:0] t);
    logic [W-1:0] q;
    q = (s == '0) ? '1 : x / s;
    return $signed(q) <= $signed(t);
  endfunction

  state_t         state_q, state_d;
  logic [W-1:0]   sk_s_q, sk_s_d, sk_t_q, sk_t_d;
  logic [LW-1:0]  wait_q, wait_d;
  logic [CW-1:0]  pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
  logic           ff_valid_q, ff_valid_d;
  logic [W-1:0]   ff_s_q, ff_s_d, ff_t_q, ff_t_d, ff_x_q, ff_x_d;
`ifdef SKOLEM_EXIST_SCAN_EN
  logic [CW-1:0]  vac_cnt_q, vac_cnt_d;
  logic [W-1:0]   xs_q, xs_d;
  logic [W-1:0]   cand_q, cand_d;
`endif

  always_comb begin
    state_d    = state_q;
    sk_s_d     = sk_s_q;
    sk_t_d     = sk_t_q;
    wait_d     = wait_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    ff_valid_d = ff_valid_q;
    ff_s_d     = ff_s_q;
    ff_t_d     = ff_t_q;
    ff_x_d     = ff_x_q;
`ifdef SKOLEM_EXIST_SCAN_EN
    vac_cnt_d  = vac_cnt_q;
    xs_d       = xs_q;
    cand_d     = cand_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sk_s_d     = '0;
          sk_t_d     = '0;
          pass_cnt_d = '0;
          fail_cnt_d = '0;
          ff_valid_d = 1'b0;
          ff_s_d     = '0;
          ff_t_d     = '0;
          ff_x_d     = '0;
`ifdef SKOLEM_EXIST_SCAN_EN
          vac_cnt_d  = '0;
`endif
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wait_d  = LAT_M1;
        state_d = (SK_LAT > 0) ? ST_WAIT : ST_CHECK;
      end
      ST_WAIT: begin
        if (wait_q == '0) state_d = ST_CHECK;
        else              wait_d  = wait_q - LW'(1);
      end
      ST_CHECK: begin
        if (holds(sk_x, sk_s_q, sk_t_q)) begin
          pass_cnt_d = pass_cnt_q + CW'(1);
          state_d    = ST_ADV;
        end else begin
`ifdef SKOLEM_EXIST_SCAN_EN
          cand_d  = sk_x;
          xs_d    = '0;
          state_d = ST_SCAN;
`else
          fail_cnt_d = fail_cnt_q + CW'(1);
          if (!ff_valid_q) begin
            ff_valid_d = 1'b1;
            ff_s_d     = sk_s_q;
            ff_t_d     = sk_t_q;
            ff_x_d     = sk_x;
          end
          state_d = ST_ADV;
`endif
        end
      end
`ifdef SKOLEM_EXIST_SCAN_EN
      ST_SCAN: begin
        if (holds(xs_q, sk_s_q, sk_t_q)) begin
          // A solution exists, so the Skolem candidate was a real failure.
          fail_cnt_d = fail_cnt_q + CW'(1);
          if (!ff_valid_q) begin
            ff_valid_d = 1'b1;
            ff_s_d     = sk_s_q;
            ff_t_d     = sk_t_q;
            ff_x_d     = cand_q;
          end
          state_d = ST_ADV;
        end else if (xs_q == '1) begin
          vac_cnt_d = vac_cnt_q + CW'(1);
          state_d   = ST_ADV;
        end else begin
          xs_d = xs_q + W'(1);
        end
      end
`endif
      ST_ADV: begin
        sk_t_d = sk_t_q + W'(1);
        if (sk_t_q == '1) sk_s_d = sk_s_q + W'(1);
        state_d = ((sk_s_q == '1) && (sk_t_q == '1)) ? ST_DONE : ST_ISSUE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sk_s_q     <= '0;
      sk_t_q     <= '0;
      wait_q     <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      ff_valid_q <= 1'b0;
      ff_s_q     <= '0;
      ff_t_q     <= '0;
      ff_x_q     <= '0;
`ifdef SKOLEM_EXIST_SCAN_EN
      vac_cnt_q  <= '0;
      xs_q       <= '0;
      cand_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sk_s_q     <= sk_s_d;
      sk_t_q     <= sk_t_d;
      wait_q     <= wait_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      ff_valid_q <= ff_valid_d;
      ff_s_q     <= ff_s_d;
      ff_t_q     <= ff_t_d;
      ff_x_q     <= ff_x_d;
`ifdef SKOLEM_EXIST_SCAN_EN
      vac_cnt_q  <= vac_cnt_d;
      xs_q       <= xs_d;
      cand_q     <= cand_d;
`endif
    end
  end

  assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done     = (state_q == ST_DONE);
  assign sk_s     = sk_s_q;
  assign sk_t     = sk_t_q;
  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;
`ifdef SKOLEM_EXIST_SCAN_EN
  assign vac_cnt  = vac_cnt_q;
`else
  assign vac_cnt  = '0;
`endif
  assign ff_valid = ff_valid_q;
  assign ff_s     = ff_s_q;
  assign ff_t     = ff_t_q;
  assign ff_x     = ff_x_q;

endmodule
